id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of a 5-stage MIPS-style pipeline.
// Holds the 32x32 register file, decodes the opcode into control bits and
// registers everything into the ID/EX pipeline register with one cycle of latency.
// A branch resolved in MEM (MEM_ctrl_pc_src_in) flushes the decoded control
// bits to a bubble; the data fields still load normally.
// Optional feature macro: ID_WB_BYPASS_EN. When it is defined, a writeback to the
// register being read in the same cycle is forwarded to the read port.
module id_stage #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [31:0]           IFID_pc_in,
   input  logic [31:0]           IFID_ir_in,
   input  logic                  MEM_ctrl_pc_src_in,
   input  logic                  WB_reg_write_in,
   input  logic [REG_ADDR_W-1:0] WB_write_reg_in,
   input  logic [31:0]           WB_write_data_in,
   output logic [31:0]           IDEX_pc_out,
   output logic [31:0]           IDEX_rs_data_out,
   output logic [31:0]           IDEX_rt_data_out,
   output logic [31:0]           IDEX_imm_out,
   output logic [4:0]            IDEX_rt_out,
   output logic [4:0]            IDEX_rd_out,
   output logic                  IDEX_reg_write_out,
   output logic                  IDEX_mem_to_reg_out,
   output logic                  IDEX_mem_read_out,
   output logic                  IDEX_mem_write_out,
   output logic                  IDEX_branch_out,
   output logic                  IDEX_alu_src_out,
   output logic                  IDEX_reg_dst_out,
   output logic [1:0]            IDEX_alu_op_out
);

   localparam int         NUM_REGS = 1 << REG_ADDR_W;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   logic [31:0]           regs_r [NUM_REGS];

   logic [5:0]            opcode_s;
   logic [REG_ADDR_W-1:0] rs_addr_s;
   logic [REG_ADDR_W-1:0] rt_addr_s;
   logic [31:0]           rs_data_s;
   logic [31:0]           rt_data_s;
   logic [31:0]           imm_s;

   logic                  reg_write_s;
   logic                  mem_to_reg_s;
   logic                  mem_read_s;
   logic                  mem_write_s;
   logic                  branch_s;
   logic                  alu_src_s;
   logic                  reg_dst_s;
   logic [1:0]            alu_op_s;

   assign opcode_s  = IFID_ir_in[31:26];
   assign rs_addr_s = IFID_ir_in[21 +: REG_ADDR_W];
   assign rt_addr_s = IFID_ir_in[16 +: REG_ADDR_W];
   assign imm_s     = {{16{IFID_ir_in[15]}}, IFID_ir_in[15:0]};

   // Register-file read ports; register 0 is hard-wired to zero.
   always_comb begin
      rs_data_s = 32'h0000_0000;
      rt_data_s = 32'h0000_0000;
      if (rs_addr_s != '0) begin
         rs_data_s = regs_r[rs_addr_s];
      end else begin
         rs_data_s = 32'h0000_0000;
      end
      if (rt_addr_s != '0) begin
         rt_data_s = regs_r[rt_addr_s];
      end else begin
         rt_data_s = 32'h0000_0000;
      end
`ifdef ID_WB_BYPASS_EN
      // Forward a same-cycle writeback so the reader sees the newest value.
      if (WB_reg_write_in && (WB_write_reg_in == rs_addr_s) && (rs_addr_s != '0)) begin
         rs_data_s = WB_write_data_in;
      end else begin
         rs_data_s = rs_data_s;
      end
      if (WB_reg_write_in && (WB_write_reg_in == rt_addr_s) && (rt_addr_s != '0)) begin
         rt_data_s = WB_write_data_in;
      end else begin
         rt_data_s = rt_data_s;
      end
`else
      // Without forwarding the reader sees the pre-write contents this cycle.
      rs_data_s = rs_data_s;
      rt_data_s = rt_data_s;
`endif
   end

   // Opcode decode into control bits; unknown opcodes become a bubble.
   always_comb begin
      reg_write_s  = 1'b0;
      mem_to_reg_s = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      branch_s     = 1'b0;
      alu_src_s    = 1'b0;
      reg_dst_s    = 1'b0;
      alu_op_s     = 2'b00;
      case (opcode_s)
         OP_RTYPE: begin
            reg_write_s = 1'b1;
            reg_dst_s   = 1'b1;
            alu_op_s    = 2'b10;
         end
         OP_LW: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = 1'b1;
            mem_read_s   = 1'b1;
            alu_src_s    = 1'b1;
            alu_op_s     = 2'b00;
         end
         OP_SW: begin
            mem_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_op_s    = 2'b00;
         end
         OP_BEQ: begin
            branch_s = 1'b1;
            alu_op_s = 2'b01;
         end
         default: begin
            alu_op_s = 2'b00;
         end
      endcase
   end

   // Register-file write port; reset clears every entry and blocks writeback.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 32'h0000_0000;
         end
      end else if (WB_reg_write_in && (WB_write_reg_in != '0)) begin
         regs_r[WB_write_reg_in] <= WB_write_data_in;
      end else begin
         regs_r[0] <= 32'h0000_0000;
      end
   end

   // ID/EX pipeline register: reset beats flush, flush zeroes only control bits.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         IDEX_pc_out         <= 32'h0000_0000;
         IDEX_rs_data_out    <= 32'h0000_0000;
         IDEX_rt_data_out    <= 32'h0000_0000;
         IDEX_imm_out        <= 32'h0000_0000;
         IDEX_rt_out         <= 5'd0;
         IDEX_rd_out         <= 5'd0;
         IDEX_reg_write_out  <= 1'b0;
         IDEX_mem_to_reg_out <= 1'b0;
         IDEX_mem_read_out   <= 1'b0;
         IDEX_mem_write_out  <= 1'b0;
         IDEX_branch_out     <= 1'b0;
         IDEX_alu_src_out    <= 1'b0;
         IDEX_reg_dst_out    <= 1'b0;
         IDEX_alu_op_out     <= 2'b00;
      end else begin
         IDEX_pc_out      <= IFID_pc_in;
         IDEX_rs_data_out <= rs_data_s;
         IDEX_rt_data_out <= rt_data_s;
         IDEX_imm_out     <= imm_s;
         IDEX_rt_out      <= IFID_ir_in[20:16];
         IDEX_rd_out      <= IFID_ir_in[15:11];
         if (MEM_ctrl_pc_src_in) begin
            IDEX_reg_write_out  <= 1'b0;
            IDEX_mem_to_reg_out <= 1'b0;
            IDEX_mem_read_out   <= 1'b0;
            IDEX_mem_write_out  <= 1'b0;
            IDEX_branch_out     <= 1'b0;
            IDEX_alu_src_out    <= 1'b0;
            IDEX_reg_dst_out    <= 1'b0;
            IDEX_alu_op_out     <= 2'b00;
         end else begin
            IDEX_reg_write_out  <= reg_write_s;
            IDEX_mem_to_reg_out <= mem_to_reg_s;
            IDEX_mem_read_out   <= mem_read_s;
            IDEX_mem_write_out  <= mem_write_s;
            IDEX_branch_out     <= branch_s;
            IDEX_alu_src_out    <= alu_src_s;
            IDEX_reg_dst_out    <= reg_dst_s;
            IDEX_alu_op_out     <= alu_op_s;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table plus randomized run against a reference model.
module tb_id_stage;

`ifdef ID_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef logic [146:0] obs_t;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      logic [31:0] e_imm;
      logic [8:0]  e_ctrl;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] IFID_pc_in;
   logic [31:0] IFID_ir_in;
   logic        MEM_ctrl_pc_src_in;
   logic        WB_reg_write_in;
   logic [4:0]  WB_write_reg_in;
   logic [31:0] WB_write_data_in;
   logic [31:0] IDEX_pc_out;
   logic [31:0] IDEX_rs_data_out;
   logic [31:0] IDEX_rt_data_out;
   logic [31:0] IDEX_imm_out;
   logic [4:0]  IDEX_rt_out;
   logic [4:0]  IDEX_rd_out;
   logic        IDEX_reg_write_out;
   logic        IDEX_mem_to_reg_out;
   logic        IDEX_mem_read_out;
   logic        IDEX_mem_write_out;
   logic        IDEX_branch_out;
   logic        IDEX_alu_src_out;
   logic        IDEX_reg_dst_out;
   logic [1:0]  IDEX_alu_op_out;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl [32];
   vec_t        tab [14];

   always #5 clk_in = ~clk_in;

   id_stage dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .IFID_pc_in          (IFID_pc_in),
      .IFID_ir_in          (IFID_ir_in),
      .MEM_ctrl_pc_src_in  (MEM_ctrl_pc_src_in),
      .WB_reg_write_in     (WB_reg_write_in),
      .WB_write_reg_in     (WB_write_reg_in),
      .WB_write_data_in    (WB_write_data_in),
      .IDEX_pc_out         (IDEX_pc_out),
      .IDEX_rs_data_out    (IDEX_rs_data_out),
      .IDEX_rt_data_out    (IDEX_rt_data_out),
      .IDEX_imm_out        (IDEX_imm_out),
      .IDEX_rt_out         (IDEX_rt_out),
      .IDEX_rd_out         (IDEX_rd_out),
      .IDEX_reg_write_out  (IDEX_reg_write_out),
      .IDEX_mem_to_reg_out (IDEX_mem_to_reg_out),
      .IDEX_mem_read_out   (IDEX_mem_read_out),
      .IDEX_mem_write_out  (IDEX_mem_write_out),
      .IDEX_branch_out     (IDEX_branch_out),
      .IDEX_alu_src_out    (IDEX_alu_src_out),
      .IDEX_reg_dst_out    (IDEX_reg_dst_out),
      .IDEX_alu_op_out     (IDEX_alu_op_out)
   );

   function automatic vec_t mk(input logic rst, input logic flush, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [31:0] pc, input logic [31:0] ir,
                               input logic [31:0] e_rs, input logic [31:0] e_rt,
                               input logic [31:0] e_imm, input logic [8:0] e_ctrl);
      vec_t v;
      v.rst = rst; v.flush = flush; v.we = we; v.wa = wa; v.wd = wd;
      v.pc = pc; v.ir = ir; v.e_rs = e_rs; v.e_rt = e_rt; v.e_imm = e_imm;
      v.e_ctrl = e_ctrl;
      return v;
   endfunction

   // Control word {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}
   function automatic logic [8:0] ctrl_of(input logic [5:0] op);
      if (op == 6'd0)       return 9'h106;  // R-type
      else if (op == 6'h23) return 9'h1C8;  // lw
      else if (op == 6'h2B) return 9'h028;  // sw
      else if (op == 6'h04) return 9'h011;  // beq
      else                  return 9'h000;  // bubble
   endfunction

   function automatic obs_t observed();
      return {IDEX_pc_out, IDEX_rs_data_out, IDEX_rt_data_out, IDEX_imm_out,
              IDEX_rt_out, IDEX_rd_out, IDEX_reg_write_out, IDEX_mem_to_reg_out,
              IDEX_mem_read_out, IDEX_mem_write_out, IDEX_branch_out,
              IDEX_alu_src_out, IDEX_reg_dst_out, IDEX_alu_op_out};
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t got;
      got = observed();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic flush, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [31:0] pc, input logic [31:0] ir);
      rst_in             = rst;
      MEM_ctrl_pc_src_in = flush;
      WB_reg_write_in    = we;
      WB_write_reg_in    = wa;
      WB_write_data_in   = wd;
      IFID_pc_in         = pc;
      IFID_ir_in         = ir;
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [31:0] mdl_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'h0;
      if (BYP && we && (wa == a)) return wd;
      return mdl[a];
   endfunction

   initial begin
      obs_t        exp;
      logic        r_rst, r_fl, r_we;
      logic [4:0]  r_wa;
      logic [31:0] r_wd, r_pc, r_ir, e_rs, e_rt;
      logic [5:0]  ops [5];

      tab[0]  = mk(1'b1, 1'b0, 1'b1, 5'd5, 32'hFFFF, 32'h1234, 32'h00221820, 32'h0, 32'h0, 32'h0, 9'h000);
      tab[1]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h4, 32'h00A50000, 32'h0, 32'h0, 32'h0, 9'h106);
      tab[2]  = mk(1'b0, 1'b0, 1'b1, 5'd1, 32'h10, 32'h8, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 9'h000);
      tab[3]  = mk(1'b0, 1'b0, 1'b1, 5'd2, 32'h20, 32'hC, 32'h10220003, 32'h10,
                   BYP ? 32'h20 : 32'h0, 32'h3, 9'h011);
      tab[4]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h10, 32'h00221820, 32'h10, 32'h20, 32'h1820, 9'h106);
      tab[5]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h14, 32'h8C24FFFC, 32'h10, 32'h0, 32'hFFFFFFFC, 9'h1C8);
      tab[6]  = mk(1'b0, 1'b1, 1'b1, 5'd7, 32'h55, 32'h18, 32'hAC220004, 32'h10, 32'h20, 32'h4, 9'h000);
      tab[7]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C, 32'h00E00000, 32'h55, 32'h0, 32'h0, 9'h106);
      tab[8]  = mk(1'b0, 1'b0, 1'b1, 5'd4, 32'hABCD, 32'h20, 32'h00800000,
                   BYP ? 32'hABCD : 32'h0, 32'h0, 32'h0, 9'h106);
      tab[9]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h24, 32'h00800000, 32'hABCD, 32'h0, 32'h0, 9'h106);
      tab[10] = mk(1'b0, 1'b0, 1'b1, 5'd0, 32'h1234, 32'h28, 32'h00000000, 32'h0, 32'h0, 32'h0, 9'h106);
      tab[11] = mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h2C, 32'h00000000, 32'h0, 32'h0, 32'h0, 9'h106);
      tab[12] = mk(1'b1, 1'b1, 1'b1, 5'd3, 32'h99, 32'h30, 32'h00221820, 32'h0, 32'h0, 32'h0, 9'h000);
      tab[13] = mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h34, 32'h00230000, 32'h0, 32'h0, 32'h0, 9'h106);

      // Directed table: each row's outputs are checked one edge after it is applied.
      for (int i = 0; i < 14; i++) begin
         drive(tab[i].rst, tab[i].flush, tab[i].we, tab[i].wa, tab[i].wd, tab[i].pc, tab[i].ir);
         if (tab[i].rst) exp = '0;
         else exp = {tab[i].pc, tab[i].e_rs, tab[i].e_rt, tab[i].e_imm,
                     tab[i].ir[20:16], tab[i].ir[15:11], tab[i].e_ctrl};
         check($sformatf("vec%0d", i), exp);
      end

      // Randomized run against the architectural model.
      ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h3F;
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
      for (int r = 0; r < 32; r++) mdl[r] = 32'h0;
      check("rand_reset", '0);
      for (int n = 0; n < 400; n++) begin
         r_rst = ($urandom_range(0, 31) == 0);
         r_fl  = ($urandom_range(0, 3) == 0);
         r_we  = ($urandom_range(0, 1) == 1);
         r_wa  = 5'($urandom_range(0, 7));
         r_wd  = $urandom;
         r_pc  = $urandom;
         r_ir  = $urandom;
         r_ir[31:26] = ($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 3)];
         r_ir[25:21] = 5'($urandom_range(0, 7));
         r_ir[20:16] = 5'($urandom_range(0, 7));
         e_rs = mdl_read(r_ir[25:21], r_we, r_wa, r_wd);
         e_rt = mdl_read(r_ir[20:16], r_we, r_wa, r_wd);
         drive(r_rst, r_fl, r_we, r_wa, r_wd, r_pc, r_ir);
         if (r_rst) begin
            exp = '0;
            for (int r = 0; r < 32; r++) mdl[r] = 32'h0;
         end else begin
            exp = {r_pc, e_rs, e_rt, {{16{r_ir[15]}}, r_ir[15:0]}, r_ir[20:16], r_ir[15:11],
                   r_fl ? 9'h000 : ctrl_of(r_ir[31:26])};
            if (r_we && (r_wa != 5'd0)) mdl[r_wa] = r_wd;
         end
         check($sformatf("rand%0d", n), exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
